// File: rtl/store_buffer_pkg.sv
// Shared types for the post-commit store buffer and its memory-controller handshake.
package store_buffer_pkg;
    localparam int unsigned XLEN        = 32;
    localparam int unsigned MASK_W      = 4;
    localparam int unsigned ROB_ID_SIZE = 4;
    localparam int unsigned ROB_ID_W    = ROB_ID_SIZE;
    localparam int unsigned SB_DEPTH    = 8;

    typedef enum logic [1:0] {
        MEM_IDLE         = 2'd0,
        MEM_RESP_WAIT    = 2'd1,
        ROB_STORE_UPDATE = 2'd2
    } mem_state_t;

    typedef enum logic {
        SB_IDLE = 1'b0,
        SB_WAIT = 1'b1
    } sb_state_t;

    typedef struct packed {
        logic                valid;
        logic                committed;
        logic [ROB_ID_W-1:0] rob_id;
        logic [XLEN-1:0]     addr;
        logic [XLEN-1:0]     wdata;
        logic [MASK_W-1:0]   wmask;
    } sb_entry_t;

    // Word-granular address compare; byte offset bits are masked off.
    function automatic logic word_match(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        return (a & ~XLEN'(3)) == (b & ~XLEN'(3));
    endfunction
endpackage

// File: rtl/store_buffer_if.sv
// LSU / ROB / memory-controller side of the store buffer, grouped as one bundle.
interface store_buffer_if;
    import store_buffer_pkg::*;

    logic                branch_mispredict;
    logic                st_valid;
    logic [XLEN-1:0]     st_addr;
    logic [XLEN-1:0]     st_wdata;
    logic [MASK_W-1:0]   st_wmask;
    logic [ROB_ID_W-1:0] st_rob_id;
    logic                commit_valid;
    logic [ROB_ID_W-1:0] commit_rob_id;
    mem_state_t          mem_state;
    logic                load_valid;
    logic [XLEN-1:0]     ld_addr;
    logic                dmem_resp;
    logic [XLEN-1:0]     dmem_addr_sb;
    logic [XLEN-1:0]     dmem_wdata_sb;
    logic [MASK_W-1:0]   dmem_wmask_sb;
    logic                sb_full;
    logic                sb_empty;
    logic                ld_conflict;

    modport master (
        output branch_mispredict, st_valid, st_addr, st_wdata, st_wmask, st_rob_id,
               commit_valid, commit_rob_id, mem_state, load_valid, ld_addr, dmem_resp,
        input  dmem_addr_sb, dmem_wdata_sb, dmem_wmask_sb, sb_full, sb_empty, ld_conflict
    );

    modport slave (
        input  branch_mispredict, st_valid, st_addr, st_wdata, st_wmask, st_rob_id,
               commit_valid, commit_rob_id, mem_state, load_valid, ld_addr, dmem_resp,
        output dmem_addr_sb, dmem_wdata_sb, dmem_wmask_sb, sb_full, sb_empty, ld_conflict
    );
endinterface

// File: rtl/store_buffer.sv
// Post-commit store queue: holds executed stores until retirement, drains them to dmem
// one at a time when memory is idle, and flags loads that hit a buffered word.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    store_buffer_if.slave sb_if
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    sb_entry_t        entries_q [DEPTH];
    sb_entry_t        entries_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] cmt_q, cmt_d;
    logic [CNT_W-1:0] count_q, count_d;
    sb_state_t        state_q, state_d;
    logic             cool_q, cool_d;

    logic             full;
    logic             empty;
    logic             enq;
    logic             do_commit;
    logic             issue;
    logic             pop;
    logic [DEPTH-1:0] hit;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    assign sb_if.sb_full  = full;
    assign sb_if.sb_empty = empty;

    assign enq = sb_if.st_valid && !full && !sb_if.branch_mispredict;

    assign do_commit = sb_if.commit_valid && entries_q[cmt_q].valid &&
                       !entries_q[cmt_q].committed &&
                       (entries_q[cmt_q].rob_id == sb_if.commit_rob_id);

    // cool_q blocks issue in the cycle right after a response (minimum 2-cycle spacing).
    assign issue = (state_q == SB_IDLE) && !cool_q &&
                   entries_q[head_q].valid && entries_q[head_q].committed &&
                   (sb_if.mem_state == MEM_IDLE) && !sb_if.load_valid;

    assign pop = (state_q == SB_WAIT) && sb_if.dmem_resp;

    // Drain FSM next-state and the zero-latency dmem request.
    always_comb begin
        state_d             = state_q;
        sb_if.dmem_addr_sb  = '0;
        sb_if.dmem_wdata_sb = '0;
        sb_if.dmem_wmask_sb = '0;
        case (state_q)
            SB_IDLE: if (issue) state_d = SB_WAIT;
            SB_WAIT: if (sb_if.dmem_resp) state_d = SB_IDLE;
            default: state_d = SB_IDLE;
        endcase
        if (issue || (state_q == SB_WAIT)) begin
            sb_if.dmem_addr_sb  = entries_q[head_q].addr & ~XLEN'(3);
            sb_if.dmem_wdata_sb = entries_q[head_q].wdata;
            sb_if.dmem_wmask_sb = entries_q[head_q].wmask;
        end
    end

    // Queue bookkeeping; commit is applied before the mispredict squash.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        cmt_d     = cmt_q;
        count_d   = count_q;
        cool_d    = pop;
        if (enq) begin
            entries_d[tail_q].valid     = 1'b1;
            entries_d[tail_q].committed = 1'b0;
            entries_d[tail_q].rob_id    = sb_if.st_rob_id;
            entries_d[tail_q].addr      = sb_if.st_addr;
            entries_d[tail_q].wdata     = sb_if.st_wdata;
            entries_d[tail_q].wmask     = sb_if.st_wmask;
            tail_d  = tail_q + PTR_W'(1);
            count_d = count_d + CNT_W'(1);
        end
        if (do_commit) begin
            entries_d[cmt_q].committed = 1'b1;
            cmt_d = cmt_q + PTR_W'(1);
        end
        if (pop) begin
            entries_d[head_q] = '0;
            head_d  = head_q + PTR_W'(1);
            count_d = count_d - CNT_W'(1);
        end
        if (sb_if.branch_mispredict) begin
            count_d = '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (!entries_d[PTR_W'(i)].committed) entries_d[PTR_W'(i)].valid = 1'b0;
                if (entries_d[PTR_W'(i)].valid) count_d = count_d + CNT_W'(1);
            end
            tail_d = cmt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SB_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            cmt_q   <= '0;
            count_q <= '0;
            cool_q  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) entries_q[PTR_W'(i)] <= '0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            cmt_q     <= cmt_d;
            count_q   <= count_d;
            cool_q    <= cool_d;
            entries_q <= entries_d;
        end
    end

    // Load-conflict CAM, including the entry currently being drained.
    for (genvar g = 0; g < DEPTH; g++) begin : g_cam
        assign hit[g] = entries_q[g].valid && word_match(entries_q[g].addr, sb_if.ld_addr);
    end
    assign sb_if.ld_conflict = |hit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(sb_if.st_valid && full))
                else $error("store_buffer: store enqueued while full was dropped");
            assert (!(sb_if.commit_valid && entries_q[cmt_q].valid && !entries_q[cmt_q].committed &&
                      (entries_q[cmt_q].rob_id != sb_if.commit_rob_id)))
                else $error("store_buffer: commit tag does not match oldest uncommitted store");
        end
    end
endmodule
